// File: rtl/clk_div_cfg_ctrl_if.sv
// ============================================================================
// Module   : clk_div_cfg_ctrl_if
// Brief    : Ratio-change request handshake between a requester and the
//            clock-divider configuration controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface clk_div_cfg_ctrl_if;
  logic       i_cfg_valid;
  logic [7:0] i_cfg_ratio;
  logic       o_cfg_ready;

  modport master (
    output i_cfg_valid,
    output i_cfg_ratio,
    input  o_cfg_ready
  );

  modport slave (
    input  i_cfg_valid,
    input  i_cfg_ratio,
    output o_cfg_ready
  );
endinterface

`default_nettype wire

// File: rtl/clk_div_cfg_ctrl.sv
// ============================================================================
// Module   : clk_div_cfg_ctrl
// Brief    : Validates divide-ratio change requests and applies them
//            glitch-safely (disable, quiesce, load, settle, re-enable).
//            Optional macro CLK_DIV_CFG_CLAMP_EN clamps ratios 0/1 to 2.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clk_div_cfg_ctrl #(
  parameter logic [7:0] DEFAULT_RATIO = 8'd8,
  parameter int         QUIESCE_CYC   = 4,
  parameter int         SETTLE_CYC    = 2
) (
  input  wire logic              i_clk_ref,
  input  wire logic              i_rst_n,
  input  wire logic              i_en_req,
  clk_div_cfg_ctrl_if.slave      cfg,
  output logic                   o_clk_en,
  output logic [7:0]             o_div_ratio,
  output logic                   o_busy,
  output logic                   o_upd_done,
  output logic                   o_cfg_err
);

  localparam logic [7:0] C_Q_LAST = 8'(QUIESCE_CYC - 1);
  localparam logic [7:0] C_S_LAST = 8'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_QUIESCE = 2'd2,
    S_SETTLE  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] ratio_q, ratio_d;
  logic       clk_en_q, clk_en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       w_accept;
  logic [7:0] w_req_ratio;
  logic       w_req_bad;

  assign cfg.o_cfg_ready = (state_q == S_IDLE);
  assign w_accept        = cfg.i_cfg_valid && (state_q == S_IDLE);

`ifdef CLK_DIV_CFG_CLAMP_EN
  always_comb begin
    w_req_ratio = (cfg.i_cfg_ratio < 8'd2) ? 8'd2 : cfg.i_cfg_ratio;
    w_req_bad   = 1'b0;
  end
`else
  always_comb begin
    w_req_ratio = cfg.i_cfg_ratio;
    w_req_bad   = (cfg.i_cfg_ratio < 8'd2);
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 8'd1;
    pend_d   = pend_q;
    ratio_d  = ratio_q;
    clk_en_d = clk_en_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d    = 8'd0;
        clk_en_d = i_en_req;
        busy_d   = 1'b0;
        if (w_accept) begin
          pend_d = w_req_ratio;
          if (w_req_bad) begin
            err_d = 1'b1;
          end else if (w_req_ratio == ratio_q) begin
            done_d = 1'b1;
          end else begin
            state_d = S_ARM;
          end
        end
      end
      // One-cycle hop so the enable drop and busy rise land on the edge after acceptance.
      S_ARM: begin
        state_d  = S_QUIESCE;
        cnt_d    = 8'd0;
        clk_en_d = 1'b0;
        busy_d   = 1'b1;
      end
      S_QUIESCE: begin
        if (cnt_q == C_Q_LAST) begin
          ratio_d = pend_q;
          state_d = S_SETTLE;
          cnt_d   = 8'd0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == C_S_LAST) begin
          state_d  = S_IDLE;
          cnt_d    = 8'd0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          clk_en_d = i_en_req;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk_ref or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      pend_q   <= DEFAULT_RATIO;
      ratio_q  <= DEFAULT_RATIO;
      clk_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      ratio_q  <= ratio_d;
      clk_en_q <= clk_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_clk_en    = clk_en_q;
  assign o_div_ratio = ratio_q;
  assign o_busy      = busy_q;
  assign o_upd_done  = done_q;
  assign o_cfg_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_cfg_ctrl.sv
// ============================================================================
// Module   : tb_clk_div_cfg_ctrl
// Brief    : Directed self-checking bench for clk_div_cfg_ctrl (Q=4, S=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_clk_div_cfg_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en_req;
  logic       clk_en;
  logic [7:0] div_ratio;
  logic       busy;
  logic       upd_done;
  logic       cfg_err;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] cur_ratio;

  clk_div_cfg_ctrl_if cfg_if ();

  clk_div_cfg_ctrl #(
    .DEFAULT_RATIO (8'd8),
    .QUIESCE_CYC   (4),
    .SETTLE_CYC    (2)
  ) dut (
    .i_clk_ref   (clk),
    .i_rst_n     (rst_n),
    .i_en_req    (en_req),
    .cfg         (cfg_if.slave),
    .o_clk_en    (clk_en),
    .o_div_ratio (div_ratio),
    .o_busy      (busy),
    .o_upd_done  (upd_done),
    .o_cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en_req = 1'b1;
    cfg_if.i_cfg_valid = 1'b0;
    cfg_if.i_cfg_ratio = 8'd0;
    repeat (3) tick();
    n_total++; if (div_ratio !== 8'd8) $display("FAIL reset_ratio: got %0d want 8", div_ratio); else n_pass++;
    n_total++; if (clk_en !== 1'b0) $display("FAIL reset_clk_en: got %b want 0", clk_en); else n_pass++;
    n_total++; if (busy !== 1'b0 || upd_done !== 1'b0 || cfg_err !== 1'b0)
      $display("FAIL reset_flags: got busy=%b done=%b err=%b want 0/0/0", busy, upd_done, cfg_err); else n_pass++;
    n_total++; if (cfg_if.o_cfg_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cfg_if.o_cfg_ready); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_total++; if (clk_en !== 1'b1) $display("FAIL reset_release_clk_en: got %b want 1", clk_en); else n_pass++;
    cur_ratio = 8'd8;
  endtask

  // Full update 8 -> 5; i counts edges after the accepting edge k.
  task automatic test_update();
    cfg_if.i_cfg_valid = 1'b1;
    cfg_if.i_cfg_ratio = 8'd5;
    tick();
    cfg_if.i_cfg_valid = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) tick();
      n_total++; if (busy !== (i >= 1 && i <= 6)) $display("FAIL upd_busy k+%0d: got %b want %b", i, busy, (i >= 1 && i <= 6)); else n_pass++;
      n_total++; if (clk_en !== (i == 0 || i >= 7)) $display("FAIL upd_clk_en k+%0d: got %b want %b", i, clk_en, (i == 0 || i >= 7)); else n_pass++;
      n_total++; if (div_ratio !== ((i >= 5) ? 8'd5 : 8'd8)) $display("FAIL upd_ratio k+%0d: got %0d want %0d", i, div_ratio, (i >= 5) ? 5 : 8); else n_pass++;
      n_total++; if (upd_done !== (i == 7) || cfg_err !== 1'b0) $display("FAIL upd_done k+%0d: got done=%b err=%b want %b/0", i, upd_done, cfg_err, (i == 7)); else n_pass++;
      n_total++; if (cfg_if.o_cfg_ready !== (i >= 7)) $display("FAIL upd_ready k+%0d: got %b want %b", i, cfg_if.o_cfg_ready, (i >= 7)); else n_pass++;
      // Enable request wiggles during the busy window must have no effect.
      if (i == 2) en_req = 1'b0;
      if (i == 6) en_req = 1'b1;
    end
    cur_ratio = 8'd5;
  endtask

  task automatic test_noop();
    cfg_if.i_cfg_valid = 1'b1;
    cfg_if.i_cfg_ratio = cur_ratio;
    tick();
    cfg_if.i_cfg_valid = 1'b0;
    n_total++; if (upd_done !== 1'b1 || cfg_err !== 1'b0) $display("FAIL noop_done: got done=%b err=%b want 1/0", upd_done, cfg_err); else n_pass++;
    n_total++; if (clk_en !== 1'b1 || busy !== 1'b0) $display("FAIL noop_en: got clk_en=%b busy=%b want 1/0", clk_en, busy); else n_pass++;
    n_total++; if (cfg_if.o_cfg_ready !== 1'b1) $display("FAIL noop_ready: got %b want 1", cfg_if.o_cfg_ready); else n_pass++;
    tick();
    n_total++; if (upd_done !== 1'b0 || clk_en !== 1'b1) $display("FAIL noop_after: got done=%b clk_en=%b want 0/1", upd_done, clk_en); else n_pass++;
    n_total++; if (div_ratio !== cur_ratio) $display("FAIL noop_ratio: got %0d want %0d", div_ratio, cur_ratio); else n_pass++;
  endtask

  task automatic test_invalid();
`ifdef CLK_DIV_CFG_CLAMP_EN
    cfg_if.i_cfg_valid = 1'b1;
    cfg_if.i_cfg_ratio = 8'd1;
    tick();
    cfg_if.i_cfg_valid = 1'b0;
    for (int i = 0; i <= 7; i++) begin
      if (i > 0) tick();
      n_total++; if (cfg_err !== 1'b0) $display("FAIL clamp_err k+%0d: got %b want 0", i, cfg_err); else n_pass++;
      n_total++; if (div_ratio !== ((i >= 5) ? 8'd2 : 8'd5)) $display("FAIL clamp_ratio k+%0d: got %0d want %0d", i, div_ratio, (i >= 5) ? 2 : 5); else n_pass++;
      n_total++; if (upd_done !== (i == 7)) $display("FAIL clamp_done k+%0d: got %b want %b", i, upd_done, (i == 7)); else n_pass++;
    end
    cur_ratio = 8'd2;
    // Ratio 0 clamps to 2, which is already current: no-op completion.
    cfg_if.i_cfg_valid = 1'b1;
    cfg_if.i_cfg_ratio = 8'd0;
    tick();
    cfg_if.i_cfg_valid = 1'b0;
    n_total++; if (upd_done !== 1'b1 || cfg_err !== 1'b0) $display("FAIL clamp0_done: got done=%b err=%b want 1/0", upd_done, cfg_err); else n_pass++;
    n_total++; if (clk_en !== 1'b1 || div_ratio !== 8'd2) $display("FAIL clamp0_state: got clk_en=%b ratio=%0d want 1/2", clk_en, div_ratio); else n_pass++;
    tick();
`else
    for (int r = 0; r < 2; r++) begin
      cfg_if.i_cfg_valid = 1'b1;
      cfg_if.i_cfg_ratio = (r == 0) ? 8'd1 : 8'd0;
      tick();
      cfg_if.i_cfg_valid = 1'b0;
      n_total++; if (cfg_err !== 1'b1 || upd_done !== 1'b0) $display("FAIL reject_err r%0d: got err=%b done=%b want 1/0", r, cfg_err, upd_done); else n_pass++;
      n_total++; if (div_ratio !== 8'd5 || cfg_if.o_cfg_ready !== 1'b1) $display("FAIL reject_state r%0d: got ratio=%0d ready=%b want 5/1", r, div_ratio, cfg_if.o_cfg_ready); else n_pass++;
      tick();
      n_total++; if (cfg_err !== 1'b0 || clk_en !== 1'b1 || busy !== 1'b0) $display("FAIL reject_after r%0d: got err=%b clk_en=%b busy=%b want 0/1/0", r, cfg_err, clk_en, busy); else n_pass++;
    end
`endif
  endtask

  // Request 6, then keep valid high with 3 through the busy window.
  task automatic test_back_to_back();
    cfg_if.i_cfg_valid = 1'b1;
    cfg_if.i_cfg_ratio = 8'd6;
    tick();
    cfg_if.i_cfg_ratio = 8'd3;
    repeat (5) tick();
    n_total++; if (div_ratio !== 8'd6) $display("FAIL b2b_first_ratio: got %0d want 6", div_ratio); else n_pass++;
    repeat (2) tick();
    n_total++; if (upd_done !== 1'b1 || cfg_if.o_cfg_ready !== 1'b1) $display("FAIL b2b_first_done: got done=%b ready=%b want 1/1", upd_done, cfg_if.o_cfg_ready); else n_pass++;
    tick();
    cfg_if.i_cfg_valid = 1'b0;
    n_total++; if (cfg_if.o_cfg_ready !== 1'b0 || upd_done !== 1'b0) $display("FAIL b2b_second_accept: got ready=%b done=%b want 0/0", cfg_if.o_cfg_ready, upd_done); else n_pass++;
    tick();
    n_total++; if (busy !== 1'b1 || clk_en !== 1'b0) $display("FAIL b2b_second_busy: got busy=%b clk_en=%b want 1/0", busy, clk_en); else n_pass++;
    repeat (6) tick();
    n_total++; if (upd_done !== 1'b1 || div_ratio !== 8'd3 || clk_en !== 1'b1) $display("FAIL b2b_second_done: got done=%b ratio=%0d clk_en=%b want 1/3/1", upd_done, div_ratio, clk_en); else n_pass++;
    tick();
    cur_ratio = 8'd3;
  endtask

  task automatic test_reset_abort();
    cfg_if.i_cfg_valid = 1'b1;
    cfg_if.i_cfg_ratio = 8'd12;
    tick();
    cfg_if.i_cfg_valid = 1'b0;
    repeat (2) tick();
    n_total++; if (busy !== 1'b1) $display("FAIL abort_pre_busy: got %b want 1", busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (div_ratio !== 8'd8 || busy !== 1'b0 || clk_en !== 1'b0) $display("FAIL abort_async: got ratio=%0d busy=%b clk_en=%b want 8/0/0", div_ratio, busy, clk_en); else n_pass++;
    n_total++; if (cfg_if.o_cfg_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", cfg_if.o_cfg_ready); else n_pass++;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_total++; if (upd_done !== 1'b0 || div_ratio !== 8'd8 || busy !== 1'b0) $display("FAIL abort_after c%0d: got done=%b ratio=%0d busy=%b want 0/8/0", i, upd_done, div_ratio, busy); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_update();
    test_noop();
    test_invalid();
    test_back_to_back();
    test_noop();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
